clocks_multiphase: RTL and testbench

- Parametrised clock/reset generator for netlist-simulated CPU cores.
- Successor of the fixed two-phase generator. Produces NPHASE non-overlapping phase clocks with a programmable high time and dead gap, plus a delayed core reset release.
- Adds run/stop and single-step control so a debug host can advance the core one machine cycle at a time.
- Sits between the board clock/reset and the core's phase-clock and reset inputs.

---
 rtl/clkgen_pkg.sv | 29 ++
 rtl/clkgen_reset_hold.sv | 35 +++
 rtl/clocks_multiphase.sv | 134 +++++++++++++
 tb/tb_clocks_multiphase.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg
// Shared definitions for the multiphase clock/reset generator:
//   - clk_state_e   : control FSM states (run / stop / single-step)
//   - clog2_width   : bits needed to hold a given number of distinct values
//   - slot_length   : eclk cycles per phase slot (high time plus dead gap)
package clkgen_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOP,
        ST_STEP
    } clk_state_e;

    localparam int DEFAULT_HALFCYCLE = 4;
    localparam int DEFAULT_GAP       = 0;
    localparam int DEFAULT_SLOT_LEN  = DEFAULT_HALFCYCLE + DEFAULT_GAP;

    // Never returns less than 1 so that single-value counters still get a bit.
    function automatic int clog2_width(input int value);
        int width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

    function automatic int slot_length(input int halfcycle, input int gap);
        return halfcycle + gap;
    endfunction

endpackage

// File: rtl/clkgen_reset_hold.sv
// clkgen_reset_hold
// Holds the core reset (res, active-low) for RESET_CYCLES eclk edges after
// ereset is released, then keeps res high until the next ereset.
// Ports:
//   eclk   - system clock
//   ereset - asynchronous active-high reset
//   res    - core reset output, 0 while holding, 1 once released
module clkgen_reset_hold
    import clkgen_pkg::*;
#(
    parameter int RESET_CYCLES = 2048
) (
    input  logic eclk,
    input  logic ereset,
    output logic res
);

    localparam int CW = clog2_width(RESET_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(RESET_CYCLES - 1);

    logic [CW-1:0] count;

    // The counter freezes once res rises, so res lands on exactly the
    // RESET_CYCLES-th edge after release and the counter never wraps.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            count <= '0;
            res   <= 1'b0;
        end else if (!res) begin
            count <= count + CW'(1);
            res   <= (count == LAST_COUNT);
        end
    end

endmodule

// File: rtl/clocks_multiphase.sv
// clocks_multiphase
// Generates NPHASE non-overlapping phase clocks (HALFCYCLE high, GAP dead
// cycles per slot) from eclk, a delayed active-low core reset, and run/stop
// plus single-step control for a debug host.
// Ports:
//   eclk, ereset  - system clock and asynchronous active-high reset
//   run           - 1 free-run, 0 halt at the next machine-cycle boundary
//   step          - one-cycle request for a single machine cycle while halted
//   res           - core reset, active-low
//   phi           - phase clocks, at most one bit high
//   phase_strb    - first high cycle of each phase
//   cycle_done    - last eclk cycle of each machine cycle
//   stopped       - halted at a boundary
//   cyc_count     - completed machine cycles
// Optional feature: define CLKGEN_CYCLE_COUNT_EN to build the cyc_count
// counter; without it cyc_count is tied to zero.
module clocks_multiphase
    import clkgen_pkg::*;
#(
    parameter int NPHASE       = 2,
    parameter int HALFCYCLE    = DEFAULT_HALFCYCLE,
    parameter int GAP          = DEFAULT_GAP,
    parameter int RESET_CYCLES = 2048
) (
    input  logic              eclk,
    input  logic              ereset,
    input  logic              run,
    input  logic              step,
    output logic              res,
    output logic [NPHASE-1:0] phi,
    output logic              phase_strb,
    output logic              cycle_done,
    output logic              stopped,
    output logic [31:0]       cyc_count
);

    localparam int SLOT_LEN = slot_length(HALFCYCLE, GAP);
    localparam int SW       = clog2_width(NPHASE);
    localparam int UW       = clog2_width(SLOT_LEN + 1);

    clk_state_e        state, state_next;
    logic [SW-1:0]     slot, slot_next;
    logic [UW-1:0]     sub, sub_next;
    logic              emit;
    logic              is_last;
    logic [NPHASE-1:0] phi_next;

    clkgen_reset_hold #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_reset_hold (
        .eclk  (eclk),
        .ereset(ereset),
        .res   (res)
    );

    // slot/sub name the position that will be presented at the next edge.
    // A halted generator sits at slot 0 / sub 0, so leaving STOP starts a
    // machine cycle cleanly. The run/stop decision is taken on the edge that
    // presents the final cycle; it is ignored while the core is still held
    // in reset so the core always sees clocks during the hold.
    always_comb begin
        state_next = state;
        emit       = 1'b1;
        is_last    = (slot == SW'(NPHASE - 1)) && (sub == UW'(SLOT_LEN - 1));

        case (state)
            ST_STOP: begin
                if (run) begin
                    state_next = ST_RUN;
                end else if (step) begin
                    state_next = ST_STEP;
                end else begin
                    emit = 1'b0;
                end
            end
            default: begin
                if (is_last) begin
                    state_next = (res && !run) ? ST_STOP : ST_RUN;
                end
            end
        endcase

        slot_next = slot;
        sub_next  = sub;
        if (emit) begin
            if (sub == UW'(SLOT_LEN - 1)) begin
                sub_next  = '0;
                slot_next = (slot == SW'(NPHASE - 1)) ? '0 : slot + SW'(1);
            end else begin
                sub_next = sub + UW'(1);
            end
        end

        for (int k = 0; k < NPHASE; k++) begin
            phi_next[k] = emit && (slot == SW'(k)) && (sub < UW'(HALFCYCLE));
        end
    end

    // Reset leaves the sequencer idle at a boundary in RUN, so the first
    // edge after release raises phi[0] together with phase_strb.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            state      <= ST_RUN;
            slot       <= '0;
            sub        <= '0;
            phi        <= '0;
            phase_strb <= 1'b0;
            cycle_done <= 1'b0;
            stopped    <= 1'b0;
        end else begin
            state      <= state_next;
            slot       <= slot_next;
            sub        <= sub_next;
            phi        <= phi_next;
            phase_strb <= emit && (sub == '0);
            cycle_done <= emit && is_last;
            stopped    <= !emit;
        end
    end

`ifdef CLKGEN_CYCLE_COUNT_EN
    // Counts on the same edge that raises cycle_done; wraps naturally.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            cyc_count <= '0;
        end else if (emit && is_last) begin
            cyc_count <= cyc_count + 32'd1;
        end
    end
`else
    assign cyc_count = '0;
`endif

endmodule

// File: tb/tb_clocks_multiphase.sv
// tb_clocks_multiphase
// Drives two generator instances from one eclk/ereset: a controllable
// two-phase instance (NPHASE=2, HALFCYCLE=4, GAP=0, RESET_CYCLES=16) and a
// free-running four-phase instance (NPHASE=4, HALFCYCLE=3, GAP=2,
// RESET_CYCLES=5). Expected outputs per edge are queued by the driver and
// compared by an independent monitor.
module tb_clocks_multiphase;

    localparam int NP   = 2;
    localparam int HC   = 4;
    localparam int GP   = 0;
    localparam int RC   = 16;
    localparam int SLOT = HC + GP;
    localparam int LEN  = NP * SLOT;

    localparam int NP4   = 4;
    localparam int HC4   = 3;
    localparam int GP4   = 2;
    localparam int RC4   = 5;
    localparam int SLOT4 = HC4 + GP4;
    localparam int LEN4  = NP4 * SLOT4;

    typedef struct {
        logic        res;
        logic [1:0]  phi;
        logic        strb;
        logic        done;
        logic        stopped;
        logic [31:0] cnt;
        logic        res4;
        logic [3:0]  phi4;
        logic        strb4;
        logic        done4;
    } exp_t;

    logic        eclk;
    logic        ereset;
    logic        run;
    logic        step;
    logic        res;
    logic [1:0]  phi;
    logic        phase_strb;
    logic        cycle_done;
    logic        stopped;
    logic [31:0] cyc_count;

    logic        res4;
    logic [3:0]  phi4;
    logic        strb4;
    logic        done4;
    logic        stopped4;
    logic [31:0] cyc_count4;

    int   errors;
    int   checks;
    bit   sim_done;
    exp_t exp_q[$];

    // Reference model state: edges since release, position inside the
    // current machine cycle, halted flag and completed cycle count.
    int          edges;
    int          pos;
    bit          halted;
    logic [31:0] cycles;

    clocks_multiphase #(
        .NPHASE(NP), .HALFCYCLE(HC), .GAP(GP), .RESET_CYCLES(RC)
    ) dut (
        .eclk(eclk), .ereset(ereset), .run(run), .step(step),
        .res(res), .phi(phi), .phase_strb(phase_strb),
        .cycle_done(cycle_done), .stopped(stopped), .cyc_count(cyc_count)
    );

    clocks_multiphase #(
        .NPHASE(NP4), .HALFCYCLE(HC4), .GAP(GP4), .RESET_CYCLES(RC4)
    ) dut4 (
        .eclk(eclk), .ereset(ereset), .run(1'b1), .step(1'b0),
        .res(res4), .phi(phi4), .phase_strb(strb4),
        .cycle_done(done4), .stopped(stopped4), .cyc_count(cyc_count4)
    );

    initial begin
        eclk = 1'b0;
        forever #5 eclk = ~eclk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Computes what both instances should show after the coming edge.
    task automatic modelEdge(input bit rst, input bit run_in, input bit step_in);
        exp_t e;
        bit   res_before;
        int   p4;
        e = '{default: '0};
        if (rst) begin
            edges  = 0;
            pos    = 0;
            halted = 1'b0;
            cycles = '0;
        end else begin
            res_before = (edges >= RC);
            edges++;
            if (halted && (run_in || step_in)) begin
                halted = 1'b0;
                pos    = 0;
            end
            if (halted) begin
                e.stopped = 1'b1;
            end else begin
                e.phi  = ((pos % SLOT) < HC) ? 2'(1 << (pos / SLOT)) : 2'b00;
                e.strb = ((pos % SLOT) == 0);
                e.done = (pos == LEN - 1);
                if (pos == LEN - 1) begin
                    cycles = cycles + 32'd1;
                    pos    = 0;
                    if (res_before && !run_in) halted = 1'b1;
                end else begin
                    pos++;
                end
            end
            e.res = (edges >= RC);
`ifdef CLKGEN_CYCLE_COUNT_EN
            e.cnt = cycles;
`else
            e.cnt = '0;
`endif
            p4      = (edges - 1) % LEN4;
            e.phi4  = ((p4 % SLOT4) < HC4) ? 4'(1 << (p4 / SLOT4)) : 4'b0000;
            e.strb4 = ((p4 % SLOT4) == 0);
            e.done4 = (p4 == LEN4 - 1);
            e.res4  = (edges >= RC4);
        end
        exp_q.push_back(e);
    endtask

    // One eclk cycle of stimulus, applied mid-cycle after the falling edge.
    task automatic applyStimulus(input bit rst, input bit run_in, input bit step_in);
        @(negedge eclk);
        #1;
        ereset = rst;
        run    = run_in;
        step   = step_in;
        modelEdge(rst, run_in, step_in);
        if (rst) begin
            #1;
            checkOutput("async_reset_res", 32'(res), 32'd0);
            checkOutput("async_reset_phi", 32'(phi), 32'd0);
            checkOutput("async_reset_phi4", 32'(phi4), 32'd0);
            checkOutput("async_reset_stopped", 32'(stopped), 32'd0);
        end
    endtask

    // Monitor: pops one expectation per edge and compares every output.
    initial begin
        exp_t e;
        while (!sim_done) begin
            @(posedge eclk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("res", 32'(res), 32'(e.res));
                checkOutput("phi", 32'(phi), 32'(e.phi));
                checkOutput("phase_strb", 32'(phase_strb), 32'(e.strb));
                checkOutput("cycle_done", 32'(cycle_done), 32'(e.done));
                checkOutput("stopped", 32'(stopped), 32'(e.stopped));
                checkOutput("cyc_count", cyc_count, e.cnt);
                checkOutput("res4", 32'(res4), 32'(e.res4));
                checkOutput("phi4", 32'(phi4), 32'(e.phi4));
                checkOutput("phase_strb4", 32'(strb4), 32'(e.strb4));
                checkOutput("cycle_done4", 32'(done4), 32'(e.done4));
                checkOutput("stopped4", 32'(stopped4), 32'd0);
            end
        end
    end

    initial begin
        bit run_r;
        errors   = 0;
        checks   = 0;
        sim_done = 1'b0;
        ereset   = 1'b1;
        run      = 1'b1;
        step     = 1'b0;
        edges    = 0;
        pos      = 0;
        halted   = 1'b0;
        cycles   = '0;

        $display("[TB] reset and hold release");
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, ($urandom % 4) == 0);
        end

        $display("[TB] ereset pulse mid-run");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] run drop, single steps, run+step resume");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] randomized run/step traffic");
        run_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 16) == 0) run_r = ~run_r;
            applyStimulus(1'b0, run_r, ($urandom % 6) == 0);
        end

        @(negedge eclk);
        @(negedge eclk);
        sim_done = 1'b1;
        @(negedge eclk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
